opb_register_simulink2ppc: RTL and testbench



---
 rtl/opb_s2p_pkg.sv | 28 ++
 rtl/opb_s2p_addr_decode.sv | 27 ++
 rtl/opb_register_simulink2ppc.sv | 183 ++++++++++++++++++
 tb/tb_opb_register_simulink2ppc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_s2p_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opb_s2p_pkg
// Brief    : Shared constants, FSM state type and STATUS packing helper for
//            the Simulink-to-PPC OPB register.
// Revision : 1.0
// ============================================================================
package opb_s2p_pkg;

    localparam int unsigned WORD_DATA    = 0;
    localparam int unsigned WORD_STATUS  = 1;

    // Bit index in OPB [0:31] numbering (bit 0 is the MSB)
    localparam int unsigned STAT_CLR_BIT = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_HOLD = 2'd2
    } s2p_state_e;

    // Returns STATUS as a numeric word: MSB = valid, overrun count right-justified.
    function automatic logic [31:0] pack_status(input logic valid, input logic [29:0] ovr);
        pack_status = {valid, 1'b0, ovr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/opb_s2p_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : opb_s2p_addr_decode
// Brief    : Combinational OPB slave window hit and word-offset decode.
// Revision : 1.0
// ============================================================================
module opb_s2p_addr_decode #(
    parameter logic [31:0] C_BASEADDR = 32'h0100_3000,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_30FF,
    parameter int          C_AWIDTH   = 32
) (
    input  logic [0:C_AWIDTH-1] abus_i,
    input  logic                select_i,
    output logic                hit_o,
    output logic [C_AWIDTH-1:0] word_o
);

    logic [C_AWIDTH-1:0] w_off;

    assign hit_o  = select_i
                 && (abus_i >= C_BASEADDR[C_AWIDTH-1:0])
                 && (abus_i <= C_HIGHADDR[C_AWIDTH-1:0]);
    assign w_off  = abus_i - C_BASEADDR[C_AWIDTH-1:0];
    assign word_o = w_off >> 2;

endmodule
`default_nettype wire

// File: rtl/opb_register_simulink2ppc.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_simulink2ppc
// Brief    : OPB slave exposing a fabric-produced 32-bit word to the PPC,
//            with freshness flag and saturating overrun counter.
//            Optional build macro: OPB_S2P_RDCLR_EN (DATA read clears valid).
// Revision : 1.0
// ============================================================================
module opb_register_simulink2ppc
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_3000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_30FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          C_OVR_WIDTH  = 16
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid,
    output logic                    user_data_read
);

    localparam logic [C_OVR_WIDTH-1:0] OVR_MAX = '1;

    s2p_state_e                state_q;
    logic                      ack_q;
    logic [0:C_OPB_DWIDTH-1]   dbus_q;
    logic                      rd_data_q;
    logic                      clr_q;
`ifdef OPB_S2P_RDCLR_EN
    logic                      cap_q;
`endif

    logic [31:0]               data_q,  data_d;
    logic                      valid_q, valid_d;
    logic [C_OVR_WIDTH-1:0]    ovr_q,   ovr_d;

    logic                      w_hit;
    logic [C_OPB_AWIDTH-1:0]   w_word;
    logic                      w_is_data;
    logic                      w_is_status;
    logic                      w_rd_sample;
    logic                      w_clr_req;
    logic [31:0]               w_rd_mux;

    logic                      unused_ok;
    logic                      unused_family;

    opb_s2p_addr_decode #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR),
        .C_AWIDTH   (C_OPB_AWIDTH)
    ) u_decode (
        .abus_i   (OPB_ABus),
        .select_i (OPB_select),
        .hit_o    (w_hit),
        .word_o   (w_word)
    );

    assign w_is_data   = (w_word == C_OPB_AWIDTH'(WORD_DATA));
    assign w_is_status = (w_word == C_OPB_AWIDTH'(WORD_STATUS));
    assign w_rd_sample = (state_q == S_IDLE) && w_hit && OPB_RNW && w_is_data;
    assign w_clr_req   = !OPB_RNW && w_is_status && OPB_DBus[STAT_CLR_BIT];

    always_comb begin
        w_rd_mux = '0;
        if (w_is_data) begin
            w_rd_mux = data_q;
        end else if (w_is_status) begin
            w_rd_mux = pack_status(valid_q, 30'(ovr_q));
        end
    end

    // Per-transaction strobes are loaded on the IDLE->ACK edge and live only
    // for the ACK cycle; HOLD blocks a second acknowledge while select stays high.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            dbus_q    <= '0;
            rd_data_q <= 1'b0;
            clr_q     <= 1'b0;
`ifdef OPB_S2P_RDCLR_EN
            cap_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_hit) begin
                        state_q   <= S_ACK;
                        ack_q     <= 1'b1;
                        dbus_q    <= OPB_RNW ? C_OPB_DWIDTH'(w_rd_mux) : '0;
                        rd_data_q <= OPB_RNW && w_is_data;
                        clr_q     <= w_clr_req;
`ifdef OPB_S2P_RDCLR_EN
                        cap_q     <= user_data_valid;
`endif
                    end
                end
                S_ACK: begin
                    state_q   <= S_HOLD;
                    ack_q     <= 1'b0;
                    dbus_q    <= '0;
                    rd_data_q <= 1'b0;
                    clr_q     <= 1'b0;
`ifdef OPB_S2P_RDCLR_EN
                    cap_q     <= 1'b0;
`endif
                end
                S_HOLD: begin
                    if (!OPB_select) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A capture that coincides with a DATA read (its sample or ack cycle) is
    // not an overrun: the reader has consumed the previous word.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clr_q) begin
            valid_d = 1'b0;
            ovr_d   = '0;
        end
`ifdef OPB_S2P_RDCLR_EN
        if (rd_data_q && !cap_q) begin
            valid_d = 1'b0;
        end
`endif
        if (user_data_valid) begin
            data_d  = user_data_in;
            valid_d = 1'b1;
            if (valid_q && !rd_data_q && !w_rd_sample && !clr_q && (ovr_q != OVR_MAX)) begin
                ovr_d = ovr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Sl_DBus        = dbus_q;
    assign Sl_xferAck     = ack_q;
    assign user_data_read = rd_data_q;
    assign Sl_errAck      = 1'b0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;

    assign unused_ok      = ^{OPB_BE, OPB_seqAddr, OPB_DBus};
    assign unused_family  = ^C_FAMILY;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_opb_register_simulink2ppc
// Brief    : Self-checking bench: table of OPB transfers with a read-data
//            scoreboard, plus sequences for capture collisions, saturation,
//            select hold and mid-transfer reset.
// Revision : 1.0
// ============================================================================
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] BASE   = 32'h0100_3000;
    localparam logic [31:0] HIGH   = 32'h0100_30FF;
    localparam logic [31:0] DATA_A = BASE;
    localparam logic [31:0] STAT_A = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_data_valid;
    logic        user_data_read;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        cap;
        logic [31:0] cap_val;
        logic [31:0] addr;
        logic        rnw;
        logic [31:0] wdata;
        logic        exp_ack;
        logic [31:0] exp_rdata;
        int          exp_pulse;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl[NV];

    opb_register_simulink2ppc dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst_n),
        .OPB_ABus        (OPB_ABus),
        .OPB_BE          (OPB_BE),
        .OPB_DBus        (OPB_DBus),
        .OPB_RNW         (OPB_RNW),
        .OPB_select      (OPB_select),
        .OPB_seqAddr     (OPB_seqAddr),
        .Sl_DBus         (Sl_DBus),
        .Sl_xferAck      (Sl_xferAck),
        .Sl_errAck       (Sl_errAck),
        .Sl_retry        (Sl_retry),
        .Sl_toutSup      (Sl_toutSup),
        .user_data_in    (user_data_in),
        .user_data_valid (user_data_valid),
        .user_data_read  (user_data_read)
    );

    always #5 clk = ~clk;

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic capture(input logic [31:0] v);
        @(posedge clk); #1;
        user_data_in    = v;
        user_data_valid = 1'b1;
        @(posedge clk); #1;
        user_data_valid = 1'b0;
    endtask

    // hold=0 drops select the cycle after the ack; cap_cycle=n pulses a capture in cycle n
    task automatic xfer(input string name, input logic [31:0] addr, input logic rnw,
                        input logic [31:0] wdata, input logic exp_ack, input logic [31:0] exp_rdata,
                        input int exp_pulse, input int hold, input int cap_cycle,
                        input logic [31:0] cap_val);
        int acks;
        int lat;
        int pulses;
        logic [31:0] got;
        logic [31:0] want;
        acks = 0; lat = 0; pulses = 0; got = '0;
        if (rnw && exp_ack) sb_q.push_back(exp_rdata);
        @(posedge clk); #1;
        OPB_ABus        = addr;
        OPB_RNW         = rnw;
        OPB_DBus        = wdata;
        OPB_select      = 1'b1;
        user_data_in    = cap_val;
        user_data_valid = (cap_cycle == 1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (Sl_xferAck) begin
                acks++;
                if (acks == 1) begin
                    lat = i;
                    got = Sl_DBus;
                end
            end
            if (user_data_read) pulses++;
            @(posedge clk); #1;
            user_data_valid = (cap_cycle == i + 1);
            if ((hold == 0 && acks > 0) || (hold > 0 && i >= hold)) OPB_select = 1'b0;
        end
        OPB_select      = 1'b0;
        user_data_valid = 1'b0;
        check({name, " ack count"}, acks, exp_ack ? 32'd1 : 32'd0);
        if (exp_ack) check({name, " ack latency"}, lat, 32'd2);
        if (rnw && exp_ack && sb_q.size() > 0) begin
            want = sb_q.pop_front();
            if (acks > 0) check({name, " read data"}, got, want);
        end
        check({name, " user_data_read pulses"}, pulses, exp_pulse);
    endtask

    function automatic vec_t mk(input logic cap, input logic [31:0] cv, input logic [31:0] a,
                                input logic rnw, input logic [31:0] wd, input logic ea,
                                input logic [31:0] er, input int ep);
        vec_t v;
        v.cap = cap; v.cap_val = cv; v.addr = a; v.rnw = rnw; v.wdata = wd;
        v.exp_ack = ea; v.exp_rdata = er; v.exp_pulse = ep;
        return v;
    endfunction

    initial begin
        rst_n           = 1'b0;
        OPB_ABus        = '0;
        OPB_BE          = 4'hF;
        OPB_DBus        = '0;
        OPB_RNW         = 1'b0;
        OPB_select      = 1'b0;
        OPB_seqAddr     = 1'b0;
        user_data_in    = '0;
        user_data_valid = 1'b0;

        tbl[0]  = mk(0, 32'h0,        DATA_A,          1, 32'h0,        1, 32'h0000_0000, 1);
        tbl[1]  = mk(0, 32'h0,        STAT_A,          1, 32'h0,        1, 32'h0000_0000, 0);
        tbl[2]  = mk(1, 32'hDEADBEEF, DATA_A,          1, 32'h0,        1, 32'hDEADBEEF,  1);
`ifdef OPB_S2P_RDCLR_EN
        tbl[3]  = mk(0, 32'h0,        STAT_A,          1, 32'h0,        1, 32'h0000_0000, 0);
`else
        tbl[3]  = mk(0, 32'h0,        STAT_A,          1, 32'h0,        1, 32'h8000_0000, 0);
`endif
        tbl[4]  = mk(0, 32'h0,        STAT_A,          0, 32'h8000_0000, 1, 32'h0,        0);
        tbl[5]  = mk(0, 32'h0,        STAT_A,          1, 32'h0,        1, 32'h0000_0000, 0);
        tbl[6]  = mk(1, 32'hA1,       BASE + 32'h10,   1, 32'h0,        1, 32'h0000_0000, 0);
        tbl[7]  = mk(1, 32'hA2,       DATA_A,          0, 32'hFFFFFFFF, 1, 32'h0,        0);
        tbl[8]  = mk(1, 32'hA3,       STAT_A,          1, 32'h0,        1, 32'h8000_0002, 0);
        tbl[9]  = mk(0, 32'h0,        DATA_A,          1, 32'h0,        1, 32'h0000_00A3, 1);
        tbl[10] = mk(0, 32'h0,        HIGH + 32'd1,    1, 32'h0,        0, 32'h0,        0);
        tbl[11] = mk(0, 32'h0,        HIGH - 32'd3,    1, 32'h0,        1, 32'h0000_0000, 0);
        tbl[12] = mk(0, 32'h0,        STAT_A,          0, 32'h7FFFFFFF, 1, 32'h0,        0);
`ifdef OPB_S2P_RDCLR_EN
        tbl[13] = mk(0, 32'h0,        STAT_A,          1, 32'h0,        1, 32'h0000_0002, 0);
`else
        tbl[13] = mk(0, 32'h0,        STAT_A,          1, 32'h0,        1, 32'h8000_0002, 0);
`endif
        tbl[14] = mk(0, 32'h0,        BASE - 32'd4,    1, 32'h0,        0, 32'h0,        0);

        repeat (3) @(posedge clk);
        #1;
        check("reset Sl_xferAck", 32'(Sl_xferAck), 32'd0);
        check("reset Sl_DBus", Sl_DBus, 32'd0);
        check("reset user_data_read", 32'(user_data_read), 32'd0);
        check("tie-offs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
        rst_n = 1'b1;

        for (int r = 0; r < NV; r++) begin
            if (tbl[r].cap) capture(tbl[r].cap_val);
            xfer($sformatf("row%0d", r), tbl[r].addr, tbl[r].rnw, tbl[r].wdata,
                 tbl[r].exp_ack, tbl[r].exp_rdata, tbl[r].exp_pulse, 0, 0, 32'h0);
        end

        // Capture in the DATA read's sample cycle: old word returned, no overrun
        xfer("collide clr", STAT_A, 0, 32'h8000_0000, 1, 32'h0, 0, 0, 0, 32'h0);
        capture(32'h11);
        xfer("collide read", DATA_A, 1, 32'h0, 1, 32'h11, 1, 0, 1, 32'h22);
        xfer("collide status", STAT_A, 1, 32'h0, 1, 32'h8000_0000, 0, 0, 0, 32'h0);
        xfer("collide next read", DATA_A, 1, 32'h0, 1, 32'h22, 1, 0, 0, 32'h0);

        // Capture in the ACK cycle of a STATUS clear: counter cleared, valid kept
        capture(32'h1);
        capture(32'h2);
        capture(32'h3);
`ifdef OPB_S2P_RDCLR_EN
        xfer("ovr three", STAT_A, 1, 32'h0, 1, 32'h8000_0002, 0, 0, 0, 32'h0);
`else
        xfer("ovr three", STAT_A, 1, 32'h0, 1, 32'h8000_0003, 0, 0, 0, 32'h0);
`endif
        xfer("clr+cap", STAT_A, 0, 32'h8000_0000, 1, 32'h0, 0, 0, 2, 32'h44);
        xfer("clr+cap status", STAT_A, 1, 32'h0, 1, 32'h8000_0000, 0, 0, 0, 32'h0);
        xfer("hold select", STAT_A, 1, 32'h0, 1, 32'h8000_0000, 0, 5, 0, 32'h0);
        xfer("clr+cap data", DATA_A, 1, 32'h0, 1, 32'h44, 1, 0, 0, 32'h0);

        // Saturation of the overrun counter
        xfer("sat clr", STAT_A, 0, 32'h8000_0000, 1, 32'h0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        user_data_in    = 32'hCAFE_0000;
        user_data_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        user_data_valid = 1'b0;
        xfer("saturate", STAT_A, 1, 32'h0, 1, 32'h8000_FFFF, 0, 0, 0, 32'h0);

        // Reset asserted during the ACK cycle
        capture(32'h5A);
        @(posedge clk); #1;
        OPB_ABus   = DATA_A;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        @(posedge clk); #1;
        check("pre-reset ack", 32'(Sl_xferAck), 32'd1);
        check("pre-reset data", Sl_DBus, 32'h5A);
        rst_n = 1'b0;
        #1;
        check("async reset ack", 32'(Sl_xferAck), 32'd0);
        check("async reset data", Sl_DBus, 32'd0);
        check("async reset rd pulse", 32'(user_data_read), 32'd0);
        OPB_select = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        xfer("post-reset status", STAT_A, 1, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0);
        xfer("post-reset data", DATA_A, 1, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
